// File: rtl/regfile_writeback.sv
// Write-back stage: merges ALU and load-response results into the register file write port,
// formats loads (byte/half extraction, sign/zero extension) and tracks pending writes per register.
module regfile_writeback #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGISTER = 32,
    localparam int AW          = $clog2(NUM_REGISTER)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    alu_valid_i,
    output logic                    alu_ready_o,
    input  logic [AW-1:0]           alu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]   alu_data_i,
    input  logic                    lsu_valid_i,
    input  logic [AW-1:0]           lsu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_data_i,
    input  logic [2:0]              lsu_funct3_i,
    input  logic [1:0]              lsu_addr_lo_i,
    input  logic                    reserve_i,
    input  logic [AW-1:0]           reserve_addr_i,
    output logic                    we_o,
    output logic [AW-1:0]           rd_addr_o,
    output logic [DATA_WIDTH-1:0]   rd_o,
    output logic [NUM_REGISTER-1:0] busy_o,
    output logic                    illegal_load_o
);

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } load_op_e;

    logic                    we_q, we_d;
    logic [AW-1:0]           rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]   rd_q, rd_d;
    logic [NUM_REGISTER-1:0] busy_q, busy_d;
    logic                    illegal_q, illegal_d;

    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    load_illegal;
    logic                    alu_accept;

    // The LSU cannot stall, so it always wins; the ALU waits whenever a load response is present.
    assign alu_ready_o = !lsu_valid_i;
    assign alu_accept  = alu_valid_i && !lsu_valid_i;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        byte_sel     = lsu_data_i[7:0];
        load_data    = '0;
        load_illegal = 1'b0;
        case (lsu_addr_lo_i)
            2'd0:    byte_sel = lsu_data_i[7:0];
            2'd1:    byte_sel = lsu_data_i[15:8];
            2'd2:    byte_sel = lsu_data_i[23:16];
            default: byte_sel = lsu_data_i[31:24];
        endcase
        half_sel = lsu_addr_lo_i[1] ? lsu_data_i[31:16] : lsu_data_i[15:0];
        case (lsu_funct3_i)
            LD_B:    load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            LD_H:    load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            LD_W:    load_data = lsu_data_i;
            LD_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            LD_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_illegal = 1'b1;
        endcase
    end

    // Writes to x0 are consumed without touching the write port; address and data hold.
    always_comb begin
        we_d      = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_d      = rd_q;
        illegal_d = 1'b0;
        if (lsu_valid_i) begin
            if (load_illegal) begin
                illegal_d = 1'b1;
            end else if (lsu_rd_addr_i != '0) begin
                we_d      = 1'b1;
                rd_addr_d = lsu_rd_addr_i;
                rd_d      = load_data;
            end
        end else if (alu_accept && (alu_rd_addr_i != '0)) begin
            we_d      = 1'b1;
            rd_addr_d = alu_rd_addr_i;
            rd_d      = alu_data_i;
        end
    end

    // Clears are applied before the set so a same-edge reservation keeps the bit owned.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[rd_addr_q] = 1'b0;
        end
        if (lsu_valid_i && load_illegal) begin
            busy_d[lsu_rd_addr_i] = 1'b0;
        end
        if (reserve_i && (reserve_addr_i != '0)) begin
            busy_d[reserve_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst_i) begin
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            rd_q      <= '0;
            busy_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            we_q      <= we_d;
            rd_addr_q <= rd_addr_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
        end
    end

    assign we_o           = we_q;
    assign rd_addr_o      = rd_addr_q;
    assign rd_o           = rd_q;
    assign busy_o         = busy_q;
    assign illegal_load_o = illegal_q;

endmodule
